// File: rtl/dest_dispatch_if.sv
// Upstream request port and per-channel downstream port of the destination dispatcher.
// A transfer happens on a rising edge where valid & ready are both high; valid must not depend on ready.
interface dest_dispatch_if #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int DEST_W   = 16,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DEST_W-1:0]   in_dest;
    logic [DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]   out_valid;
    logic [NUM_CH-1:0]   out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                err_valid;
    logic [1:0]          err_code;
    logic [DEST_W-1:0]   err_dest;
    logic [ERRCNT_W-1:0] err_cnt;
    logic                busy;

    // master: the dispatcher itself; slave: the surrounding producer/consumers.
    modport master (
        input  in_valid, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_data, err_valid, err_code, err_dest, err_cnt, busy
    );
    modport slave (
        output in_valid, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_valid, err_code, err_dest, err_cnt, busy
    );
endinterface

// File: rtl/dest_dispatch.sv
// Single-request dispatcher: routes one tagged request to one of NUM_CH channels,
// reporting unmapped destinations and consumer timeouts with a saturating error count.
module dest_dispatch #(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 32,
    parameter int                DEST_W    = 16,
    parameter logic [DEST_W-1:0] BASE_DEST = '0,
    parameter int                TIMEOUT   = 255,
    parameter int                ERRCNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dest_dispatch_if.master bus,
    output logic [1:0]      state_o
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t              state_cs, state_ns;
    logic [DEST_W-1:0]   dest_q;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   out_valid_q, out_valid_d;
    logic                err_valid_q;
    logic [1:0]          err_code_q, err_code_d;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [DEST_W:0] offset;
    logic            mapped;
    logic            hs;
    logic            in_ready;
    logic            accept;
    logic            timeout;

    // One extra bit so codes below BASE_DEST wrap to a huge offset and read as unmapped.
    assign offset  = {1'b0, bus.in_dest} - {1'b0, BASE_DEST};
    assign mapped  = offset < (DEST_W + 1)'(NUM_CH);
    assign hs      = |(out_valid_q & bus.out_ready);
    assign accept  = bus.in_valid & in_ready;
    assign timeout = (TIMEOUT != 0) && (state_cs == DISPATCH) && (timer_q == TMR_LAST) && !hs;

    always_comb begin
        in_ready = 1'b0;
        case (state_cs)
            IDLE:     in_ready = 1'b1;
            DISPATCH: in_ready = hs;
            default:  in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_ns   = state_cs;
        err_code_d = 2'b00;
        case (state_cs)
            IDLE: begin
                if (accept) state_ns = mapped ? DISPATCH : ERR;
            end
            DISPATCH: begin
                if (hs)           state_ns = accept ? (mapped ? DISPATCH : ERR) : IDLE;
                else if (timeout) state_ns = ERR;
            end
            ERR:     state_ns = IDLE;
            default: state_ns = IDLE;
        endcase
        // The only way into ERR without an accept is the timeout path.
        if (state_ns == ERR) err_code_d = accept ? 2'b01 : 2'b10;
    end

    always_comb begin
        sel_d       = accept ? offset[SEL_W-1:0] : sel_q;
        out_valid_d = (state_ns == DISPATCH) ? (NUM_CH'(1) << sel_d) : '0;
        timer_d     = timer_q;
        if (state_ns != DISPATCH || state_cs != DISPATCH || hs) timer_d = '0;
        else if (timer_q != '1)                                 timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_cs    <= IDLE;
            dest_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            out_valid_q <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_cnt_q   <= '0;
            timer_q     <= '0;
        end else begin
            state_cs    <= state_ns;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            timer_q     <= timer_d;
            err_valid_q <= (state_ns == ERR);
            err_code_q  <= err_code_d;
            if (accept)           dest_q <= bus.in_dest;
            // Unmapped requests never reach a channel, so out_data keeps the last delivered payload.
            if (accept && mapped) data_q <= bus.in_data;
            if (state_ns == ERR && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.err_dest  = dest_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = (state_cs != IDLE);
    assign state_o       = state_cs;
endmodule

// File: tb/tb_dest_dispatch.sv
// Randomized scoreboard bench for dest_dispatch: delivery order, error reporting,
// timeout length, back-to-back throughput and error counter saturation.
module tb_dest_dispatch;
    localparam int          NUM_CH = 4;
    localparam int          DATA_W = 32;
    localparam int          DEST_W = 16;
    localparam logic [15:0] BASE   = 16'h0010;
    localparam int          TMO    = 8;
    localparam int          ECW    = 8;
    localparam int          EW     = 54;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_fail = 0;
    int err_model = 0;
    logic [EW-1:0] exp_q[$];

    dest_dispatch_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W), .ERRCNT_W(ECW)) bus ();

    dest_dispatch #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W),
        .BASE_DEST(BASE), .TIMEOUT(TMO), .ERRCNT_W(ECW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_o(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // entry layout: kind(0 deliver, 1 unmapped, 2 timeout), channel, dest, data
    function automatic logic [EW-1:0] pack_exp(input int kind, input int ch,
                                               input logic [15:0] dest, input logic [31:0] data);
        logic [1:0] k;
        logic [3:0] c;
        k = 2'(kind);
        c = 4'(ch);
        return {k, c, dest, data};
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic [3:0] ready_vec(input int ch, input bit sel_rdy);
        logic [3:0] r;
        r = 4'($urandom_range(0, 15));
        r[ch] = sel_rdy;
        return r;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [3:0]    oh;
        if (rst_n) begin
            if (|(bus.out_valid & bus.out_ready)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_delivery: got out_valid %0h expected none", bus.out_valid);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e[51:48];
                    check("deliver_kind", 64'(0), 64'(e[53:52]));
                    check("deliver_channel", 64'(bus.out_valid), 64'(oh));
                    check("deliver_data", 64'(bus.out_data), 64'(e[31:0]));
                end
            end
            if (bus.err_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_error: got err_code %0h expected none", bus.err_code);
                end else begin
                    e = exp_q.pop_front();
                    check("err_code", 64'(bus.err_code), 64'(e[53:52]));
                    check("err_dest", 64'(bus.err_dest), 64'(e[47:32]));
                    check("err_out_valid", 64'(bus.out_valid), 64'(0));
                end
            end
        end
    end

    // driver: one request, then a consumer that becomes ready 'delay' cycles into dispatch
    task automatic do_txn(input logic [15:0] dest, input logic [31:0] data, input int delay);
        int off, ch, exp_cycles, cnt;
        bit mapped, acc, done;
        off    = int'(dest) - int'(BASE);
        mapped = (off >= 0) && (off < NUM_CH);
        ch     = mapped ? off : 0;
        if (!mapped) begin
            exp_q.push_back(pack_exp(1, 0, dest, data));
            err_model++;
            exp_cycles = 0;
        end else if (delay >= TMO) begin
            exp_q.push_back(pack_exp(2, ch, dest, data));
            err_model++;
            exp_cycles = TMO;
        end else begin
            exp_q.push_back(pack_exp(0, ch, dest, data));
            exp_cycles = delay + 1;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_dest   = dest;
        bus.in_data   = data;
        bus.out_ready = 4'($urandom_range(0, 15));
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_wait: got no in_ready expected accept for dest %0h", dest);
        end
        cnt  = 0;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            bus.out_ready = ready_vec(ch, mapped && (t >= delay));
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
            else begin
                if (|bus.out_valid) cnt++;
                @(posedge clk); #1;
            end
        end
        check("txn_done", 64'(done), 64'(1));
        check("out_valid_cycles", 64'(cnt), 64'(exp_cycles));
        check("err_cnt", 64'(bus.err_cnt), 64'(sat_cnt(err_model)));
    endtask

    // driver: consecutive requests with every consumer ready
    task automatic b2b(input int n);
        logic [15:0] d;
        logic [31:0] x;
        int          ch;
        bit          done;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ch = (i % 3 == 2) ? 3 : (i % 3);
            d  = 16'(BASE + 16'(ch));
            x  = $urandom;
            bus.in_valid = 1'b1;
            bus.in_dest  = d;
            bus.in_data  = x;
            exp_q.push_back(pack_exp(0, ch, d, x));
            @(negedge clk);
            check("b2b_in_ready", 64'(bus.in_ready), 64'(1));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        check("b2b_done", 64'(done), 64'(1));
    endtask

    function automatic logic [15:0] rand_dest();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5)      return 16'(BASE + 16'($urandom_range(0, NUM_CH - 1)));
        else if (r == 6) return 16'(BASE - 16'd1);
        else if (r == 7) return 16'(BASE + 16'(NUM_CH));
        else if (r == 8) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_dest   = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_err_valid", 64'(bus.err_valid), 64'(0));
        check("rst_err_code", 64'(bus.err_code), 64'(0));
        check("rst_err_dest", 64'(bus.err_dest), 64'(0));
        check("rst_err_cnt", 64'(bus.err_cnt), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // reset in the middle of a dispatch drops the request silently
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_dest  = 16'h0011;
        bus.in_data  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_out_data", 64'(bus.out_data), 64'(0));
        check("midrst_err_cnt", 64'(bus.err_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        do_txn(16'h0012, 32'hDEADBEEF, 0);
        do_txn(16'h0014, 32'h11111111, 0);
        do_txn(16'hFFFF, 32'h22222222, 0);
        do_txn(16'h0004, 32'h33333333, 0);
        do_txn(16'h000F, 32'h44444444, 0);
        do_txn(16'h0011, 32'h55555555, TMO);
        do_txn(16'h0011, 32'h66666666, TMO - 1);
        do_txn(16'h0013, 32'h77777777, 3);
        b2b(3);
        b2b(7);

        for (int i = 0; i < 200; i++)
            do_txn(rand_dest(), $urandom, int'($urandom_range(0, 11)));

        // enough errors to push the counter into saturation
        for (int i = 0; i < 300; i++)
            do_txn(16'(BASE + 16'(NUM_CH) + 16'($urandom_range(0, 100))), $urandom, 0);
        check("err_cnt_saturated", 64'(bus.err_cnt), 64'(255));

        repeat (5) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dest_dispatch.md
Name: dest_dispatch

Overview:
- Parametrised single-request dispatcher. Accepts one tagged request (destination code plus data) on an upstream valid/ready port and routes it to one of NUM_CH downstream channels.
- Sits between the register/command front end and per-destination consumers.
- Extends the single fixed-destination FSM with:
  - a configurable channel count and widths,
  - unmapped-destination error reporting,
  - a per-transaction timeout,
  - a saturating error counter.

Parameters:
NUM_CH, 4, number of downstream channels (1..16)
DATA_W, 32, payload width
DEST_W, 16, destination code width
BASE_DEST, 16'h0000, code of channel 0; channel i maps to code BASE_DEST+i
TIMEOUT, 255, max cycles waiting for out_ready before drop; 0 disables timeout
ERRCNT_W, 8, error counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream request valid
in_ready  output  1  upstream ready
in_dest  input  DEST_W  destination code
in_data  input  DATA_W  payload
out_valid  output  NUM_CH  per-channel valid, at most one bit set
out_ready  input  NUM_CH  per-channel ready
out_data  output  DATA_W  payload shared by all channels
err_valid  output  1  one-cycle error pulse
err_code  output  2  01 unmapped dest, 10 timeout, 00 none
err_dest  output  DEST_W  destination code of the failed request
err_cnt  output  ERRCNT_W  saturating count of errors since reset
busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous, active-low. Reset is fixed.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, err_valid=0, err_code=0, err_dest=0, err_cnt=0, busy=0, timer=0.
  - Reset asserted mid-transaction drops the pending request silently: no error is reported, no channel sees it.
- FSM states: IDLE, DISPATCH, ERR. Encoding is a typed enum; registered state_cs, combinational state_ns with default hold.
- in_ready:
  - 1 in IDLE.
  - 1 in DISPATCH on the cycle the selected channel completes its handshake (out_valid[sel] & out_ready[sel]).
  - 0 in ERR and at all other times.
- Accept:
  - Occurs on in_valid & in_ready. Latch dest, data, and sel = in_dest - BASE_DEST.
  - Mapped means (in_dest - BASE_DEST) < NUM_CH. Compute the subtraction at DEST_W+1 bits so codes below BASE_DEST underflow and are classified unmapped.
- Transitions:
  - IDLE -> DISPATCH on accept with a mapped dest.
  - IDLE -> ERR on accept with an unmapped dest.
  - DISPATCH, on handshake:
    - with no new accept -> IDLE;
    - with a new accept -> DISPATCH (mapped) or ERR (unmapped). This gives back-to-back throughput of one transaction per cycle when the consumer is always ready.
  - DISPATCH -> ERR on timeout: TIMEOUT != 0 and timer == TIMEOUT-1 and no handshake in that cycle.
  - ERR -> IDLE unconditionally after 1 cycle.
- Latency: the accept cycle registers the request. out_valid[sel] and out_data are valid from the next cycle and held stable until the handshake.
- Timer:
  - Cleared on every entry to DISPATCH; increments each DISPATCH cycle without a handshake.
  - Width is clog2(TIMEOUT+1); the timer never wraps.
  - Timeout and handshake in the same cycle: the handshake wins, no error.
- ERR cycle: err_valid=1, err_code as above, err_dest = latched dest. out_valid=0 throughout ERR, including the timeout-drop cycle (out_valid falls the cycle the FSM enters ERR).
- err_cnt: increments on each err_valid pulse and saturates at all-ones.
- out_data: holds its last value when out_valid=0. No X propagation.
- out_ready on non-selected channels is ignored.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, in_ready=1, busy=0. Assert rst_n=0 mid-DISPATCH -> out_valid=0 asynchronously, err_cnt unchanged at 0.
- in_dest=16'h0002, in_data=32'hDEADBEEF, out_ready=4'b0100 -> out_valid=4'b0100 with out_data=DEADBEEF one cycle after accept; handshake; back to IDLE; no error.
- Three back-to-back requests to dests 0,1,3 with all out_ready=1 -> accepted on consecutive cycles; out_valid sequence 0001, 0010, 1000; in_ready stays 1.
- in_dest=16'h0004 (NUM_CH=4) and separately 16'hFFFF with BASE_DEST=16'h0010 -> no out_valid; err_valid pulse with err_code=01; err_dest = the offending dest; err_cnt=2.
- TIMEOUT=8, dest 1, out_ready held 0 -> out_valid[1] high for exactly 8 cycles, then err_code=10, err_dest=1, out_valid=0. Repeat with out_ready rising on the 8th cycle -> handshake, no error.
- Force 300 errors with ERRCNT_W=8 -> err_cnt saturates at 255.
